instr_register_alu: RTL and testbench

Parametrised successor to the lab instruction register. It stores DEPTH instruction words (opcode, two signed operands) and computes each result in hardware through a two-stage write pipeline. Each stored word carries the result, an error flag and a written/valid bit. The block sits under the class-based testbench as the DUT, and its registered read port returns a complete, self-checkable instruction word.

---
 rtl/instr_register_alu_if.sv | 45 ++++
 rtl/instr_register_alu.sv | 172 +++++++++++++++++
 tb/tb_instr_register_alu.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_register_alu_if.sv
// instr_register_alu_if
//   Bundle of the write, read and status signals of instr_register_alu.
//   Clock and reset are not part of the bundle.
//   Parameters: OP_WIDTH (operand width), DEPTH (entries, power of two).
//   Write side : load_en, write_pointer, opcode, operand_a, operand_b
//   Read side  : read_en, read_pointer
//   Returned   : rd_valid, rd_opcode, rd_operand_a, rd_operand_b, rd_result,
//                rd_err, rd_empty, wr_count
//   master = stimulus side, slave = the register block.
interface instr_register_alu_if #(
  parameter int OP_WIDTH = 32,
  parameter int DEPTH    = 32
);
  localparam int AW = $clog2(DEPTH);

  logic                    load_en;
  logic [AW-1:0]           write_pointer;
  logic [2:0]              opcode;
  logic [OP_WIDTH-1:0]     operand_a;
  logic [OP_WIDTH-1:0]     operand_b;
  logic                    read_en;
  logic [AW-1:0]           read_pointer;
  logic                    rd_valid;
  logic [2:0]              rd_opcode;
  logic [OP_WIDTH-1:0]     rd_operand_a;
  logic [OP_WIDTH-1:0]     rd_operand_b;
  logic [2*OP_WIDTH-1:0]   rd_result;
  logic                    rd_err;
  logic                    rd_empty;
  logic [AW:0]             wr_count;

  modport master (
    output load_en, write_pointer, opcode, operand_a, operand_b,
    output read_en, read_pointer,
    input  rd_valid, rd_opcode, rd_operand_a, rd_operand_b, rd_result,
    input  rd_err, rd_empty, wr_count
  );

  modport slave (
    input  load_en, write_pointer, opcode, operand_a, operand_b,
    input  read_en, read_pointer,
    output rd_valid, rd_opcode, rd_operand_a, rd_operand_b, rd_result,
    output rd_err, rd_empty, wr_count
  );
endinterface

// File: rtl/instr_register_alu.sv
// instr_register_alu
//   DEPTH-entry instruction register. Each write carries an opcode and two
//   signed operands; the result is computed in a two-stage write pipeline
//   (S1 capture, S2 compute + commit) and stored with an error flag and a
//   written bit. A registered read port returns the whole stored word.
//   Ports:
//     clk   - rising-edge clock
//     reset - synchronous, active-high
//     bus   - instr_register_alu_if.slave (write, read and status signals)
//   Build option:
//     INSTR_REG_DIV_EN - when defined, DIV/MOD use a real divider; when
//                        undefined, DIV/MOD store result=0, err=1.
module instr_register_alu #(
  parameter int OP_WIDTH = 32,
  parameter int DEPTH    = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  instr_register_alu_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int RW = 2 * OP_WIDTH;

  typedef enum logic [2:0] {
    OP_ZERO  = 3'd0,
    OP_PASSA = 3'd1,
    OP_PASSB = 3'd2,
    OP_ADD   = 3'd3,
    OP_SUB   = 3'd4,
    OP_MULT  = 3'd5,
    OP_DIV   = 3'd6,
    OP_MOD   = 3'd7
  } opcode_e;

  typedef struct packed {
    opcode_e             op;
    logic [OP_WIDTH-1:0] a;
    logic [OP_WIDTH-1:0] b;
    logic [RW-1:0]       result;
    logic                err;
  } entry_t;

  // S1 pipeline registers
  logic                s1_valid;
  logic [AW-1:0]       s1_ptr;
  opcode_e             s1_op;
  logic [OP_WIDTH-1:0] s1_a;
  logic [OP_WIDTH-1:0] s1_b;

  // Storage
  entry_t              mem [DEPTH];
  logic [DEPTH-1:0]    written;
  logic [AW:0]         wr_count_q;

  // S2 datapath
  logic signed [RW-1:0] a_ext;
  logic signed [RW-1:0] b_ext;
  logic signed [RW-1:0] result;
  logic                 err;

  // Read port registers
  logic                rd_valid_q;
  logic [2:0]          rd_opcode_q;
  logic [OP_WIDTH-1:0] rd_a_q;
  logic [OP_WIDTH-1:0] rd_b_q;
  logic [RW-1:0]       rd_result_q;
  logic                rd_err_q;
  logic                rd_empty_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= bus.load_en;
      if (bus.load_en) begin
        s1_ptr <= bus.write_pointer;
        s1_op  <= opcode_e'(bus.opcode);
        s1_a   <= bus.operand_a;
        s1_b   <= bus.operand_b;
      end
    end
  end

  always_comb begin
    a_ext  = {{OP_WIDTH{s1_a[OP_WIDTH-1]}}, s1_a};
    b_ext  = {{OP_WIDTH{s1_b[OP_WIDTH-1]}}, s1_b};
    result = '0;
    err    = 1'b0;
    case (s1_op)
      OP_ZERO:  result = '0;
      OP_PASSA: result = a_ext;
      OP_PASSB: result = b_ext;
      OP_ADD:   result = a_ext + b_ext;
      OP_SUB:   result = a_ext - b_ext;
      // Operands are sign-extended to RW bits, so the RW-bit product is exact.
      OP_MULT:  result = a_ext * b_ext;
`ifdef INSTR_REG_DIV_EN
      // Signed / truncates toward zero and % follows the dividend's sign.
      OP_DIV: begin
        if (b_ext == '0) err = 1'b1;
        else             result = a_ext / b_ext;
      end
      OP_MOD: begin
        if (b_ext == '0) err = 1'b1;
        else             result = a_ext % b_ext;
      end
`else
      OP_DIV:   err = 1'b1;
      OP_MOD:   err = 1'b1;
`endif
    endcase
  end

  // Array data is not reset; the written bits alone define emptiness.
  always_ff @(posedge clk) begin
    if (!reset && s1_valid) begin
      mem[s1_ptr] <= '{op: s1_op, a: s1_a, b: s1_b, result: result, err: err};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      written    <= '0;
      wr_count_q <= '0;
    end else if (s1_valid) begin
      written[s1_ptr] <= 1'b1;
      if (!written[s1_ptr]) wr_count_q <= wr_count_q + (AW+1)'(1);
    end
  end

  // Reads sample mem/written before this edge's commit lands, which gives
  // read-before-write on a same-address collision.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid_q  <= 1'b0;
      rd_opcode_q <= '0;
      rd_a_q      <= '0;
      rd_b_q      <= '0;
      rd_result_q <= '0;
      rd_err_q    <= 1'b0;
      rd_empty_q  <= 1'b0;
    end else begin
      rd_valid_q <= bus.read_en;
      if (bus.read_en) begin
        if (written[bus.read_pointer]) begin
          rd_opcode_q <= mem[bus.read_pointer].op;
          rd_a_q      <= mem[bus.read_pointer].a;
          rd_b_q      <= mem[bus.read_pointer].b;
          rd_result_q <= mem[bus.read_pointer].result;
          rd_err_q    <= mem[bus.read_pointer].err;
          rd_empty_q  <= 1'b0;
        end else begin
          rd_opcode_q <= '0;
          rd_a_q      <= '0;
          rd_b_q      <= '0;
          rd_result_q <= '0;
          rd_err_q    <= 1'b0;
          rd_empty_q  <= 1'b1;
        end
      end
    end
  end

  assign bus.rd_valid     = rd_valid_q;
  assign bus.rd_opcode    = rd_opcode_q;
  assign bus.rd_operand_a = rd_a_q;
  assign bus.rd_operand_b = rd_b_q;
  assign bus.rd_result    = rd_result_q;
  assign bus.rd_err       = rd_err_q;
  assign bus.rd_empty     = rd_empty_q;
  assign bus.wr_count     = wr_count_q;
endmodule

// File: tb/tb_instr_register_alu.sv
// tb_instr_register_alu
//   Bench for instr_register_alu: directed scenarios followed by random
//   traffic, every output checked each cycle against a reference model.
//   Follows INSTR_REG_DIV_EN the same way as the design build.
module tb_instr_register_alu;
  localparam int OP_WIDTH = 32;
  localparam int DEPTH    = 32;
  localparam int AW       = $clog2(DEPTH);

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  instr_register_alu_if #(.OP_WIDTH(OP_WIDTH), .DEPTH(DEPTH)) bus ();

  instr_register_alu #(.OP_WIDTH(OP_WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Reference model state
  bit     m_wr  [DEPTH];
  int     m_op  [DEPTH];
  int     m_a   [DEPTH];
  int     m_b   [DEPTH];
  longint m_res [DEPTH];
  bit     m_err [DEPTH];
  bit     p_v;
  int     p_ptr, p_op, p_a, p_b;
  bit     e_valid, e_empty, e_err;
  int     e_op, e_a, e_b;
  longint e_res;

  int n_cmp;
  int n_bad;

  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Arithmetic from the opcode definitions, with explicit truncating division.
  task automatic ref_alu(input int op, input int a, input int b,
                         output longint res, output bit err);
    longint la, lb, q, ma, mb;
    la = a;
    lb = b;
    res = 0;
    err = 1'b0;
    case (op)
      0: res = 0;
      1: res = la;
      2: res = lb;
      3: res = la + lb;
      4: res = la - lb;
      5: res = la * lb;
      default: begin
`ifdef INSTR_REG_DIV_EN
        if (lb == 0) begin
          err = 1'b1;
        end else begin
          ma = (la < 0) ? -la : la;
          mb = (lb < 0) ? -lb : lb;
          q  = ma / mb;
          if ((la < 0) != (lb < 0)) q = -q;
          res = (op == 6) ? q : la - q * lb;
        end
`else
        err = 1'b1;
        q = 0; ma = 0; mb = 0;
`endif
      end
    endcase
  endtask

  function automatic int model_count();
    int c = 0;
    for (int i = 0; i < DEPTH; i++) c += m_wr[i] ? 1 : 0;
    return c;
  endfunction

  task automatic model_edge(input bit rst, input bit le, input int wp, input int op,
                            input int a, input int b, input bit re, input int rp);
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) m_wr[i] = 1'b0;
      p_v = 1'b0;
      e_valid = 1'b0; e_empty = 1'b0; e_err = 1'b0;
      e_op = 0; e_a = 0; e_b = 0; e_res = 0;
    end else begin
      e_valid = re;
      if (re) begin
        if (m_wr[rp]) begin
          e_empty = 1'b0; e_op = m_op[rp]; e_a = m_a[rp]; e_b = m_b[rp];
          e_res = m_res[rp]; e_err = m_err[rp];
        end else begin
          e_empty = 1'b1; e_op = 0; e_a = 0; e_b = 0; e_res = 0; e_err = 1'b0;
        end
      end
      if (p_v) begin
        m_wr[p_ptr] = 1'b1;
        m_op[p_ptr] = p_op;
        m_a[p_ptr]  = p_a;
        m_b[p_ptr]  = p_b;
        ref_alu(p_op, p_a, p_b, m_res[p_ptr], m_err[p_ptr]);
      end
      p_v = le; p_ptr = wp; p_op = op; p_a = a; p_b = b;
    end
  endtask

  task automatic check_all();
    check("rd_valid",  bus.rd_valid, e_valid);
    check("rd_empty",  bus.rd_empty, e_empty);
    check("rd_err",    bus.rd_err, e_err);
    check("rd_opcode", bus.rd_opcode, e_op);
    check("rd_operand_a", $signed(bus.rd_operand_a), e_a);
    check("rd_operand_b", $signed(bus.rd_operand_b), e_b);
    check("rd_result", bus.rd_result, e_res);
    check("wr_count",  bus.wr_count, model_count());
  endtask

  task automatic step(input bit rst, input bit le, input int wp, input int op,
                      input int a, input int b, input bit re, input int rp);
    reset             = rst;
    bus.load_en       = le;
    bus.write_pointer = wp[AW-1:0];
    bus.opcode        = op[2:0];
    bus.operand_a     = a;
    bus.operand_b     = b;
    bus.read_en       = re;
    bus.read_pointer  = rp[AW-1:0];
    @(posedge clk);
    model_edge(rst, le, wp % DEPTH, op % 8, a, b, re, rp % DEPTH);
    #1;
    check_all();
  endtask

  task automatic wr(input int p, input int op, input int a, input int b);
    step(1'b0, 1'b1, p, op, a, b, 1'b0, 0);
  endtask

  task automatic rd(input int p);
    step(1'b0, 1'b0, 0, 0, 0, 0, 1'b1, p);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 0, 0, 0, 0, 1'b0, 0);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 0, 0, 0, 0, 1'b0, 0);
  endtask

  function automatic int rand_operand();
    case ($urandom_range(0, 3))
      0:       return 0;
      1:       return int'($urandom_range(0, 20)) - 10;
      default: return int'($urandom);
    endcase
  endfunction

  initial begin
    int min_int;
    int c0;
    int ndist;
    bit seen [DEPTH];
    n_cmp = 0;
    n_bad = 0;
    p_v = 1'b0;
    min_int = int'(32'h8000_0000);

    do_reset();
    do_reset();
    check("reset_wr_count", bus.wr_count, 0);
    for (int i = 0; i < DEPTH; i++) begin
      rd(i);
      check("empty_after_reset", bus.rd_empty, 1);
    end

    wr(3, 3, 7, -3);
    rd(3);
    check("early_read_empty", bus.rd_empty, 1);
    rd(3);
    check("add_result", bus.rd_result, 4);
    check("add_wr_count", bus.wr_count, 1);

    wr(5, 5, min_int, 2);
    wr(6, 4, min_int, 1);
    idle();
    rd(5);
    check("mult_full_width", bus.rd_result, -64'sd4294967296);
    rd(6);
    check("sub_full_width", bus.rd_result, -64'sd2147483649);

    wr(7, 6, -7, 2);
    wr(8, 7, -7, 2);
    wr(9, 6, 9, 0);
    wr(10, 6, 9, 2);
    idle();
    rd(9);
    check("div_by_zero_result", bus.rd_result, 0);
    check("div_by_zero_err", bus.rd_err, 1);
    rd(7);
`ifdef INSTR_REG_DIV_EN
    check("div_trunc", bus.rd_result, -3);
    rd(8);
    check("mod_sign", bus.rd_result, -1);
    rd(10);
    check("div_plain", bus.rd_result, 4);
    check("div_plain_err", bus.rd_err, 0);
`else
    check("div_disabled_err", bus.rd_err, 1);
    rd(10);
    check("div_disabled_result", bus.rd_result, 0);
    check("div_disabled_err2", bus.rd_err, 1);
`endif

    c0 = int'(bus.wr_count);
    wr(1, 1, 5, 0);
    wr(1, 2, 0, 9);
    idle();
    check("overwrite_count", bus.wr_count, c0 + 1);
    rd(1);
    check("overwrite_result", bus.rd_result, 9);

    do_reset();
    ndist = 0;
    for (int i = 0; i < DEPTH; i++) seen[i] = 1'b0;
    for (int i = 0; i < 20; i++) begin
      int p;
      p = int'($urandom_range(0, DEPTH - 1));
      if (!seen[p]) ndist++;
      seen[p] = 1'b1;
      wr(p, int'($urandom_range(0, 7)), rand_operand(), rand_operand());
    end
    idle();
    idle();
    check("distinct_count", bus.wr_count, ndist);

    wr(2, 3, 1, 1);
    do_reset();
    rd(2);
    check("reset_discards_write", bus.rd_empty, 1);
    check("reset_discards_count", bus.wr_count, 0);

    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0,
           int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 7)),
           rand_operand(), rand_operand(), $urandom_range(0, 3) != 0,
           int'($urandom_range(0, DEPTH - 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
